fp_unit_arbiter: RTL and testbench
==================================

// Module: fp_unit_arbiter
// PURPOSE
//  Shares one in-order, pipelined floating-point unit (FPU) among NUM_REQ requesters.
//  - Round-robin arbitration of operand requests.
//  - Tracks the requester index (tag) of every in-flight operation.
//  - Routes each returned result to its originating requester.
//  - Sits between accelerator lanes and the shared FPU; its result port feeds the FP checker.
// PARAMETERS
//  NUM_REQ          4   number of requesters (>=2)
//  EXP_WIDTH        8   exponent width
//  FRAC_WIDTH       24  fraction width incl. hidden bit; DATA_WIDTH = EXP_WIDTH+FRAC_WIDTH
//  MAX_OUTSTANDING  8   max ops issued but not yet returned (tag FIFO depth, power of 2)
// PORTS
//  clkIn        in   1                   clock
//  rstIn        in   1                   asynchronous, active-high reset
//  reqValidIn   in   NUM_REQ             per-requester op valid
//  reqReadyOut  out  NUM_REQ             per-requester accept (one-hot or zero)
//  reqAIn       in   NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DW +: DW]
//  reqBIn       in   NUM_REQ*DATA_WIDTH  operand B, same packing
//  reqOpIn      in   NUM_REQ*2           op code, packing [i*2 +: 2]
//  fpuValidOut  out  1                   op presented to FPU
//  fpuReadyIn   in   1                   FPU accepts op this cycle
//  fpuAOut      out  DATA_WIDTH          operand A to FPU
//  fpuBOut      out  DATA_WIDTH          operand B to FPU
//  fpuOpOut     out  2                   op code to FPU
//  fpuValidIn   in   1                   FPU result valid (in issue order, no backpressure)
//  fpuResultIn  in   DATA_WIDTH          FPU result
//  rspValidOut  out  NUM_REQ             one-hot result strobe
//  rspDataOut   out  DATA_WIDTH          result data (shared bus)
//  errorOut     out  1                   sticky protocol error
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = 0; tag FIFO empty, count = 0; errorOut = 0.
//  issueEn = (!fpuValidOut || fpuReadyIn) && (count < MAX_OUTSTANDING).
//  Grant: combinational.
//  - Scan reqValidIn from rr pointer upward, wrapping modulo NUM_REQ.
//  - The first valid requester g gets reqReadyOut[g] = issueEn; all others 0.
//  - reqReadyOut never depends on fpuValidIn; a same-cycle pop does not free a slot.
//  Accept (reqValidIn[g] && reqReadyOut[g]):
//  - Next cycle: fpuValidOut = 1; fpuA/B/Op hold g's operands and op code.
//  - Push tag g into the FIFO; rr pointer <= (g+1) mod NUM_REQ.
//  - No accept: rr pointer is unchanged.
//  FPU handshake:
//  - fpuValidOut and its data hold stable until fpuReadyIn.
//  - On transfer with no new accept, fpuValidOut <= 0.
//  - Transfer plus new accept in the same cycle gives back-to-back issue, 1 op/cycle.
//  count: ops accepted minus results returned; includes the op held in the output register.
//  Return (fpuValidIn):
//  - Pop head tag t.
//  - Next cycle: rspValidOut = one-hot(t), rspDataOut = fpuResultIn.
//  - No result: rspValidOut = 0 and rspDataOut holds its last value.
//  Simultaneous push and pop: count unchanged; FIFO pointers both advance, wrap modulo depth.
//  fpuValidIn with FIFO empty:
//  - errorOut <= 1 (sticky until reset); no rspValidOut; count stays 0.
//  Latency: accept -> fpuValidOut is 1 cycle; fpuValidIn -> rspValidOut is 1 cycle.
//  Arithmetic: tag width = $clog2(NUM_REQ); count width = $clog2(MAX_OUTSTANDING)+1.
//  Reset mid-operation:
//  - In-flight tags are discarded; the FPU must be reset together with this block.
//  - Any late fpuValidIn then sets errorOut.
// STRUCTURE
//  fp_pkg:
//  - EXP_WIDTH/FRAC_WIDTH defaults, DATA_WIDTH.
//  - Op codes FP_OP_ADD=0, FP_OP_SUB=1, FP_OP_MUL=2, FP_OP_DIV=3.
//  - Function clog2.
//  Sub-module fp_tag_fifo:
//  - Synchronous FIFO, width clog2(NUM_REQ), depth MAX_OUTSTANDING.
//  - Provides push, pop, head, count, empty and full.
//  - Pop when empty is ignored and flagged.
//  Top level: round-robin grant logic, FPU output register, response register, error flag.
// TESTING
//  1. Single op: req1 ADD, A=0x3F800000, B=0x40000000.
//     -> fpuValidOut 1 cycle later; result 0x40400000 on rspValidOut=0b0010.
//  2. All 4 requesters valid continuously, fpuReadyIn=1.
//     -> grants in order 0,1,2,3,0,...; one op per cycle; no requester starved.
//  3. fpuReadyIn=0 for 3 cycles while fpuValidOut=1.
//     -> FPU outputs stable; reqReadyOut=0; issue resumes the cycle fpuReadyIn=1.
//  4. 8 ops issued, no results returned.
//     -> reqReadyOut=0 at count=8; one fpuValidIn reopens a slot next cycle.
//  5. fpuValidIn pulsed with nothing in flight -> errorOut=1 and stays 1.
//     No rspValidOut is asserted; reset clears errorOut.
//  6. Interleaved results returning while new ops are accepted.
//     -> each rspValidOut matches issue order and requester; compare against a scoreboard.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default formats, op codes and a
// constant-foldable log2 helper used to size tags and counters.
package fp_pkg;

  localparam int unsigned DEF_EXP_WIDTH  = 8;
  localparam int unsigned DEF_FRAC_WIDTH = 24;
  localparam int unsigned DEF_DATA_WIDTH = DEF_EXP_WIDTH + DEF_FRAC_WIDTH;

  typedef enum logic [1:0] {
    FP_OP_ADD = 2'd0,
    FP_OP_SUB = 2'd1,
    FP_OP_MUL = 2'd2,
    FP_OP_DIV = 2'd3
  } fp_op_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fp_tag_fifo.sv
// Synchronous FIFO holding the requester tag of every in-flight FPU op.
// Pop on empty is dropped and reported through underflow_o.
module fp_tag_fifo
  import fp_pkg::*;
#(
  parameter int unsigned Width = 2,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           head_o,
  output logic [clog2(Depth):0]      count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       underflow_o
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    // Depth is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop_ok) count_d = count_q + CntW'(1);
    if (pop_ok && !push_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  always_comb begin
    head_o      = mem_q[rd_ptr_q];
    count_o     = count_q;
    empty_o     = (count_q == '0);
    full_o      = (count_q == CntW'(Depth));
    underflow_o = pop_i && empty_o;
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one in-order pipelined FPU among NUM_REQ requesters;
// tags each issued op and steers returning results back to their owner.
module fp_unit_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned EXP_WIDTH       = DEF_EXP_WIDTH,
  parameter int unsigned FRAC_WIDTH      = DEF_FRAC_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                  clkIn,
  input  logic                                  rstIn,
  input  logic [NUM_REQ-1:0]                    reqValidIn,
  output logic [NUM_REQ-1:0]                    reqReadyOut,
  input  logic [NUM_REQ*(EXP_WIDTH+FRAC_WIDTH)-1:0] reqAIn,
  input  logic [NUM_REQ*(EXP_WIDTH+FRAC_WIDTH)-1:0] reqBIn,
  input  logic [NUM_REQ*2-1:0]                  reqOpIn,
  output logic                                  fpuValidOut,
  input  logic                                  fpuReadyIn,
  output logic [EXP_WIDTH+FRAC_WIDTH-1:0]       fpuAOut,
  output logic [EXP_WIDTH+FRAC_WIDTH-1:0]       fpuBOut,
  output logic [1:0]                            fpuOpOut,
  input  logic                                  fpuValidIn,
  input  logic [EXP_WIDTH+FRAC_WIDTH-1:0]       fpuResultIn,
  output logic [NUM_REQ-1:0]                    rspValidOut,
  output logic [EXP_WIDTH+FRAC_WIDTH-1:0]       rspDataOut,
  output logic                                  errorOut
);

  localparam int unsigned DataW = EXP_WIDTH + FRAC_WIDTH;
  localparam int unsigned TagW  = clog2(NUM_REQ);
  localparam int unsigned CntW  = clog2(MAX_OUTSTANDING) + 1;

  logic [TagW-1:0]    rr_q, rr_d;
  logic [TagW-1:0]    gnt_idx, scan_idx;
  logic               gnt_found, issue_en, accept;

  logic               fpu_valid_q;
  logic [DataW-1:0]   fpu_a_q, fpu_b_q;
  logic [1:0]         fpu_op_q;

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0]   rsp_data_q;
  logic               error_q;

  logic [TagW-1:0]    fifo_head;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_empty, fifo_full, fifo_underflow, pop_ok;

  // Grant: first valid requester at or after the rr pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = TagW'((32'(rr_q) + i) % NUM_REQ);
      if (!gnt_found && reqValidIn[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    // The op parked in the output register already counts as outstanding.
    issue_en = (!fpu_valid_q || fpuReadyIn) && (fifo_count < CntW'(MAX_OUTSTANDING));
    accept   = gnt_found && issue_en;

    reqReadyOut = '0;
    if (accept) reqReadyOut[gnt_idx] = 1'b1;

    rr_d = rr_q;
    if (accept) rr_d = (gnt_idx == TagW'(NUM_REQ - 1)) ? '0 : gnt_idx + TagW'(1);
  end

  always_comb begin
    pop_ok      = fpuValidIn && !fifo_empty;
    rsp_valid_d = '0;
    if (pop_ok) rsp_valid_d[fifo_head] = 1'b1;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      rr_q        <= '0;
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      fpu_op_q    <= '0;
    end else begin
      rr_q <= rr_d;
      if (accept) begin
        fpu_valid_q <= 1'b1;
        fpu_a_q     <= reqAIn[32'(gnt_idx) * DataW +: DataW];
        fpu_b_q     <= reqBIn[32'(gnt_idx) * DataW +: DataW];
        fpu_op_q    <= reqOpIn[32'(gnt_idx) * 2 +: 2];
      end else if (fpuReadyIn) begin
        fpu_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      error_q     <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      if (pop_ok) rsp_data_q <= fpuResultIn;
      if (fifo_underflow) error_q <= 1'b1;
    end
  end

  fp_tag_fifo #(
    .Width (TagW),
    .Depth (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i       (clkIn),
    .rst_i       (rstIn),
    .push_i      (accept && !fifo_full),
    .data_i      (gnt_idx),
    .pop_i       (fpuValidIn),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .underflow_o (fifo_underflow)
  );

  assign fpuValidOut = fpu_valid_q;
  assign fpuAOut     = fpu_a_q;
  assign fpuBOut     = fpu_b_q;
  assign fpuOpOut    = fpu_op_q;
  assign rspValidOut = rsp_valid_q;
  assign rspDataOut  = rsp_data_q;
  assign errorOut    = error_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: directed table, hand sequences and random traffic
// checked against a queue-based model of grant order and tag return.
module tb_fp_unit_arbiter;
  import fp_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clkIn = 1'b0;
  logic              rstIn = 1'b1;
  logic [N-1:0]      reqValidIn = '0;
  logic [N-1:0]      reqReadyOut;
  logic [N*DW-1:0]   reqAIn = '0;
  logic [N*DW-1:0]   reqBIn = '0;
  logic [N*2-1:0]    reqOpIn = '0;
  logic              fpuValidOut;
  logic              fpuReadyIn = 1'b0;
  logic [DW-1:0]     fpuAOut, fpuBOut;
  logic [1:0]        fpuOpOut;
  logic              fpuValidIn = 1'b0;
  logic [DW-1:0]     fpuResultIn = '0;
  logic [N-1:0]      rspValidOut;
  logic [DW-1:0]     rspDataOut;
  logic              errorOut;

  fp_unit_arbiter #(
    .NUM_REQ         (N),
    .EXP_WIDTH       (8),
    .FRAC_WIDTH      (24),
    .MAX_OUTSTANDING (8)
  ) dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .reqValidIn  (reqValidIn),
    .reqReadyOut (reqReadyOut),
    .reqAIn      (reqAIn),
    .reqBIn      (reqBIn),
    .reqOpIn     (reqOpIn),
    .fpuValidOut (fpuValidOut),
    .fpuReadyIn  (fpuReadyIn),
    .fpuAOut     (fpuAOut),
    .fpuBOut     (fpuBOut),
    .fpuOpOut    (fpuOpOut),
    .fpuValidIn  (fpuValidIn),
    .fpuResultIn (fpuResultIn),
    .rspValidOut (rspValidOut),
    .rspDataOut  (rspDataOut),
    .errorOut    (errorOut)
  );

  always #5 clkIn = ~clkIn;

  int errors = 0;
  int checks = 0;

  // Model state: tags in flight kept as a plain queue in issue order.
  int          m_rr;
  int          m_q[$];
  bit          m_fv;
  logic [31:0] m_fa, m_fb, m_rspd;
  logic [1:0]  m_fop;
  logic [3:0]  m_rspv;
  bit          m_err;

  // DUT values captured at the last sample point.
  logic [3:0]  s_rdy, s_rspv;
  logic        s_fv, s_err;
  logic [31:0] s_a, s_b, s_rspd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_q.delete(); m_fv = 0; m_fa = '0; m_fb = '0; m_fop = '0;
    m_rspv = '0; m_rspd = '0; m_err = 0;
  endtask

  task automatic do_reset();
    reqValidIn = '0; fpuReadyIn = 0; fpuValidIn = 0;
    rstIn = 1'b1;
    @(posedge clkIn); #1;
    chk("rst_reqReady", 32'(reqReadyOut), 0);
    chk("rst_fpuValid", 32'(fpuValidOut), 0);
    chk("rst_fpuA", fpuAOut, 0);
    chk("rst_fpuB", fpuBOut, 0);
    chk("rst_fpuOp", 32'(fpuOpOut), 0);
    chk("rst_rspValid", 32'(rspValidOut), 0);
    chk("rst_rspData", rspDataOut, 0);
    chk("rst_error", 32'(errorOut), 0);
    rstIn = 1'b0;
    model_reset();
  endtask

  // One clock: drive, sample and compare against the model, advance model.
  task automatic cycle(input logic [3:0] vld, input bit frdy, input bit fvin,
                       input logic [31:0] res);
    bit       issue;
    int       g;
    int       t;
    logic [3:0] want_rdy;
    reqValidIn = vld; fpuReadyIn = frdy; fpuValidIn = fvin; fpuResultIn = res;
    #1;
    issue = (!m_fv || frdy) && (m_q.size() < 8);
    g = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_rr + i) % N;
      if (g < 0 && vld[k]) g = k;
    end
    want_rdy = (g >= 0 && issue) ? 4'(1 << g) : 4'b0;
    s_rdy = reqReadyOut; s_fv = fpuValidOut; s_a = fpuAOut; s_b = fpuBOut;
    s_rspv = rspValidOut; s_rspd = rspDataOut; s_err = errorOut;
    chk("reqReadyOut", 32'(reqReadyOut), 32'(want_rdy));
    chk("fpuValidOut", 32'(fpuValidOut), 32'(m_fv));
    chk("fpuAOut", fpuAOut, m_fa);
    chk("fpuBOut", fpuBOut, m_fb);
    chk("fpuOpOut", 32'(fpuOpOut), 32'(m_fop));
    chk("rspValidOut", 32'(rspValidOut), 32'(m_rspv));
    chk("rspDataOut", rspDataOut, m_rspd);
    chk("errorOut", 32'(errorOut), 32'(m_err));
    m_rspv = '0;
    if (fvin) begin
      if (m_q.size() > 0) begin
        t = m_q.pop_front();
        m_rspv = 4'(1 << t);
        m_rspd = res;
      end else begin
        m_err = 1;
      end
    end
    if (want_rdy != 0) begin
      m_q.push_back(g);
      m_rr = (g + 1) % N;
      m_fv = 1;
      m_fa = reqAIn[g*DW +: DW];
      m_fb = reqBIn[g*DW +: DW];
      m_fop = reqOpIn[g*2 +: 2];
    end else if (frdy) begin
      m_fv = 0;
    end
    @(posedge clkIn); #1;
  endtask

  typedef struct {
    logic [3:0] vld;
    bit         frdy;
    bit         fvin;
    logic [3:0] want_rdy;
    logic       want_fv;
    logic [3:0] want_rspv;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Round robin, fill to 8 outstanding, slot reopen, 3-cycle FPU stall.
    tbl[0]  = '{4'hF, 1, 0, 4'b0001, 0, 4'b0000};
    tbl[1]  = '{4'hF, 1, 0, 4'b0010, 1, 4'b0000};
    tbl[2]  = '{4'hF, 1, 0, 4'b0100, 1, 4'b0000};
    tbl[3]  = '{4'hF, 1, 0, 4'b1000, 1, 4'b0000};
    tbl[4]  = '{4'hF, 1, 0, 4'b0001, 1, 4'b0000};
    tbl[5]  = '{4'hF, 1, 0, 4'b0010, 1, 4'b0000};
    tbl[6]  = '{4'hF, 1, 0, 4'b0100, 1, 4'b0000};
    tbl[7]  = '{4'hF, 1, 0, 4'b1000, 1, 4'b0000};
    tbl[8]  = '{4'hF, 1, 0, 4'b0000, 1, 4'b0000};
    tbl[9]  = '{4'hF, 1, 1, 4'b0000, 0, 4'b0000};
    tbl[10] = '{4'hF, 1, 0, 4'b0001, 0, 4'b0001};
    tbl[11] = '{4'hF, 0, 1, 4'b0000, 1, 4'b0000};
    tbl[12] = '{4'hF, 0, 0, 4'b0000, 1, 4'b0010};
    tbl[13] = '{4'hF, 0, 0, 4'b0000, 1, 4'b0000};
    tbl[14] = '{4'hF, 1, 0, 4'b0010, 1, 4'b0000};

    model_reset();
    do_reset();

    // Single op from requester 1.
    reqAIn[1*DW +: DW] = 32'h3F80_0000;
    reqBIn[1*DW +: DW] = 32'h4000_0000;
    reqOpIn[1*2 +: 2]  = FP_OP_ADD;
    cycle(4'b0010, 1, 0, 32'h0);
    chk("single_ready", 32'(s_rdy), 32'b0010);
    cycle(4'b0000, 1, 0, 32'h0);
    chk("single_fpuValid", 32'(s_fv), 1);
    chk("single_fpuA", s_a, 32'h3F80_0000);
    chk("single_fpuB", s_b, 32'h4000_0000);
    cycle(4'b0000, 1, 1, 32'h4040_0000);
    cycle(4'b0000, 1, 0, 32'h0);
    chk("single_rspValid", 32'(s_rspv), 32'b0010);
    chk("single_rspData", s_rspd, 32'h4040_0000);

    do_reset();
    for (int i = 0; i < N; i++) begin
      reqAIn[i*DW +: DW] = 32'h1000_0000 + 32'(i);
      reqBIn[i*DW +: DW] = 32'h2000_0000 + 32'(i << 4);
      reqOpIn[i*2 +: 2]  = 2'(i);
    end
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].vld, tbl[i].frdy, tbl[i].fvin, $urandom);
      chk($sformatf("tbl%0d_ready", i), 32'(s_rdy), 32'(tbl[i].want_rdy));
      chk($sformatf("tbl%0d_fpuValid", i), 32'(s_fv), 32'(tbl[i].want_fv));
      chk($sformatf("tbl%0d_rspValid", i), 32'(s_rspv), 32'(tbl[i].want_rspv));
    end

    // Random traffic: results only for ops already handed to the FPU.
    for (int k = 0; k < 600; k++) begin
      int outstanding;
      for (int i = 0; i < N; i++) begin
        reqAIn[i*DW +: DW] = $urandom;
        reqBIn[i*DW +: DW] = $urandom;
        reqOpIn[i*2 +: 2]  = 2'($urandom_range(0, 3));
      end
      outstanding = m_q.size() - int'(m_fv);
      cycle(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            (outstanding > 0) && ($urandom_range(0, 99) < (k < 300 ? 30 : 70)), $urandom);
    end

    for (int k = 0; k < 40 && m_q.size() > 0; k++)
      cycle(4'b0000, 1, (m_q.size() - int'(m_fv)) > 0, $urandom);
    chk("no_spurious_error", 32'(s_err), 0);

    // Result with nothing in flight: sticky error, no response strobe.
    cycle(4'b0000, 1, 1, 32'hDEAD_BEEF);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0000, 1, 0, 32'h0);
      chk("err_sticky", 32'(s_err), 1);
      chk("err_no_rsp", 32'(s_rspv), 0);
    end
    do_reset();
    cycle(4'b0000, 1, 0, 32'h0);
    chk("err_cleared", 32'(s_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
